pipeline_issue_ctrl: RTL and testbench

//  Front-end scheduler for the global-stall address pipeline (PIPELINE_DEPTH stages, one shared in_stall).
//  - Round-robin arbitration of N_REQ requesters onto the pipeline input.
//  - Drives the pipeline's global stall from downstream backpressure.
//  - Bounds in-flight entries with a credit counter.
//  - Sequences flush and drain requests.

---
 rtl/pipeline_issue_ctrl_pkg.sv | 7 +
 rtl/pipeline_issue_ctrl_rr_arbiter.sv | 31 +++
 rtl/pipeline_issue_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_issue_ctrl_pkg.sv
// pipeline_issue_ctrl_pkg: pipeline widths and issue-controller FSM encodings
package pipeline_issue_ctrl_pkg;
  localparam int ADDRESS_WIDTH = 16;
  localparam int ID_WIDTH = 4;
  localparam int PIPELINE_DEPTH = 4;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_DRAIN = 2'd2} state_t;
endpackage

// File: rtl/pipeline_issue_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the winner on accept
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] win
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr;
  logic found;
  always_comb begin
    grant = '0;
    win = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + i) % N);
      end
    end
    grant[win] = en & found;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (en && found) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: round-robin issue, global stall, credits and flush/drain sequencing
module pipeline_issue_ctrl
  import pipeline_issue_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_INFLIGHT = PIPELINE_DEPTH,
  parameter int CNT_W = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [N_REQ*ID_WIDTH-1:0]      req_id,
  output logic [N_REQ-1:0]               req_ready,
  input  logic                           flush_req,
  input  logic [ID_WIDTH-1:0]            flush_req_id,
  output logic                           flush_ack,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [ADDRESS_WIDTH-1:0]       pipe_address,
  output logic [ID_WIDTH-1:0]            pipe_id,
  output logic                           pipe_valid,
  output logic                           pipe_flush,
  output logic [ID_WIDTH-1:0]            pipe_flush_id,
  output logic                           pipe_stall,
  input  logic                           pipe_out_valid,
  input  logic                           down_ready,
  output logic [CNT_W-1:0]               inflight
);
  state_t state, state_n;
  logic retire, eligible, issue, drained, done;
  logic [$clog2(N_REQ)-1:0] win;
  assign pipe_stall = pipe_out_valid & ~down_ready;
  assign retire = pipe_out_valid & down_ready;
  assign eligible = (state == ST_RUN) & ~pipe_stall & (inflight < CNT_W'(MAX_INFLIGHT)) & ~flush_req;
  assign issue = |req_ready;
  assign pipe_flush = state == ST_FLUSH;
  assign flush_ack = pipe_flush;
  assign drained = (state == ST_DRAIN) & (inflight == '0);
  // done remembers that this drain already reported, so the pulse is single
  assign drain_done = drained & ~done;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk,
    .rst(reset),
    .req(req_valid),
    .en(eligible),
    .grant(req_ready),
    .win
  );
  always_comb begin
    state_n = state;
    if (state == ST_FLUSH) state_n = drain_req ? ST_DRAIN : ST_RUN;
    else if (flush_req && !pipe_stall) state_n = ST_FLUSH;
    else if (state == ST_RUN && drain_req && !flush_req) state_n = ST_DRAIN;
    else if (drained && !drain_req) state_n = ST_RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      inflight <= '0;
      done <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_address <= '0;
      pipe_id <= '0;
      pipe_flush_id <= '0;
    end else begin
      state <= state_n;
      inflight <= inflight + CNT_W'(issue) - CNT_W'(retire && inflight != '0);
      done <= (state_n != ST_RUN) & (done | drain_done);
      if (state_n == ST_FLUSH) pipe_flush_id <= flush_req_id;
      if (!pipe_stall) begin
        pipe_valid <= issue;
        if (issue) begin
          pipe_address <= req_address[int'(win)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          pipe_id <= req_id[int'(win)*ID_WIDTH +: ID_WIDTH];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (!(retire && inflight == '0));
  end
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// tb_pipeline_issue_ctrl: scenario tasks with a scoreboard of expected pipeline-input entries
module tb_pipeline_issue_ctrl;
  import pipeline_issue_ctrl_pkg::*;
  localparam int N = 4, MAXI = PIPELINE_DEPTH, AW = ADDRESS_WIDTH, IW = ID_WIDTH, CW = 4;
  typedef struct packed {logic [AW-1:0] addr; logic [IW-1:0] id;} ent_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*AW-1:0] req_address = '0;
  logic [N*IW-1:0] req_id = '0;
  logic flush_req = 1'b0, flush_ack, drain_req = 1'b0, drain_done;
  logic [IW-1:0] flush_req_id = '0, pipe_id, pipe_flush_id;
  logic [AW-1:0] pipe_address;
  logic pipe_valid, pipe_flush, pipe_stall, pipe_out_valid = 1'b0, down_ready = 1'b1;
  logic [CW-1:0] inflight;
  ent_t exp_q[$];
  ent_t e;
  int n_cmp = 0, n_bad = 0, tb_ptr = 0, tb_inf = 0;

  pipeline_issue_ctrl #(.N_REQ(N), .MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address), .req_id(req_id),
    .req_ready(req_ready), .flush_req(flush_req), .flush_req_id(flush_req_id), .flush_ack(flush_ack),
    .drain_req(drain_req), .drain_done(drain_done), .pipe_address(pipe_address), .pipe_id(pipe_id),
    .pipe_valid(pipe_valid), .pipe_flush(pipe_flush), .pipe_flush_id(pipe_flush_id),
    .pipe_stall(pipe_stall), .pipe_out_valid(pipe_out_valid), .down_ready(down_ready),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [IW-1:0] i);
    req_address[k*AW +: AW] = a;
    req_id[k*IW +: IW] = i;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; flush_req = 1'b0; drain_req = 1'b0;
    pipe_out_valid = 1'b0; down_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete(); tb_ptr = 0; tb_inf = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({pipe_valid, pipe_flush, flush_ack, drain_done, pipe_stall} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {pipe_valid, pipe_flush, flush_ack, drain_done, pipe_stall}); end
    n_cmp++; if (pipe_address !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", pipe_address); end
    n_cmp++; if (pipe_id !== '0) begin n_bad++; $display("FAIL reset_id got %h want 0", pipe_id); end
    n_cmp++; if (pipe_flush_id !== '0) begin n_bad++; $display("FAIL reset_flush_id got %h want 0", pipe_flush_id); end
    n_cmp++; if (inflight !== '0) begin n_bad++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_rr_ptr got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 16'h0010, 4'd3);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
    exp_q.push_back(ent_t'{16'h0010, 4'd3});
    tick();
    req_valid = '0;
    e = exp_q.pop_front();
    n_cmp++; if (pipe_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", pipe_valid); end
    n_cmp++; if ({pipe_address, pipe_id} !== {e.addr, e.id}) begin n_bad++; $display("FAIL single_entry got %h/%h want %h/%h", pipe_address, pipe_id, e.addr, e.id); end
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL single_inflight got %0d want 1", inflight); end
    tick();
    n_cmp++; if (pipe_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", pipe_valid); end
    pipe_out_valid = 1'b1;
    tick();
    pipe_out_valid = 1'b0;
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL single_retire got %0d want 0", inflight); end
  endtask

  task automatic test_round_robin();
    int w;
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 16'h0100 + 16'(k), IW'(k + 8));
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      pipe_out_valid = (c >= 6);
      #1;
      w = (tb_inf < MAXI) ? pick(req_valid, tb_ptr) : -1;
      exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp_rdy); end
      if (w >= 0) begin
        exp_q.push_back(ent_t'{16'h0100 + 16'(w), IW'(w + 8)});
        tb_ptr = (w + 1) % N;
      end
      tb_inf = tb_inf + int'(w >= 0) - int'(c >= 6);
      tick();
      n_cmp++; if (pipe_valid !== (w >= 0)) begin n_bad++; $display("FAIL rr_valid c=%0d got %b want %b", c, pipe_valid, (w >= 0)); end
      if (w >= 0) begin
        e = exp_q.pop_front();
        n_cmp++; if ({pipe_address, pipe_id} !== {e.addr, e.id}) begin n_bad++; $display("FAIL rr_entry c=%0d got %h/%h want %h/%h", c, pipe_address, pipe_id, e.addr, e.id); end
      end
      n_cmp++; if (inflight !== CW'(tb_inf)) begin n_bad++; $display("FAIL rr_inflight c=%0d got %0d want %0d", c, inflight, tb_inf); end
    end
    req_valid = '0;
    pipe_out_valid = 1'b1;
    repeat (tb_inf) tick();
    pipe_out_valid = 1'b0;
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL rr_cleanup got %0d want 0", inflight); end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 16'h0020, 4'd1);
    set_req(1, 16'h0021, 4'd2);
    req_valid = 4'b0001;
    exp_q.push_back(ent_t'{16'h0020, 4'd1});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if ({pipe_valid, pipe_address, pipe_id} !== {1'b1, e.addr, e.id}) begin n_bad++; $display("FAIL stall_first got %b/%h/%h want 1/%h/%h", pipe_valid, pipe_address, pipe_id, e.addr, e.id); end
    req_valid = 4'b0010; pipe_out_valid = 1'b1; down_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({pipe_stall, req_ready} !== 5'b10000) begin n_bad++; $display("FAIL stall_comb c=%0d got stall=%b ready=%b want 1/0000", c, pipe_stall, req_ready); end
      tick();
      n_cmp++; if ({pipe_valid, pipe_address, pipe_id} !== {1'b1, e.addr, e.id}) begin n_bad++; $display("FAIL stall_hold c=%0d got %b/%h/%h want 1/%h/%h", c, pipe_valid, pipe_address, pipe_id, e.addr, e.id); end
      n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL stall_inflight c=%0d got %0d want 1", c, inflight); end
    end
    down_ready = 1'b1;
    #1;
    n_cmp++; if ({pipe_stall, req_ready} !== 5'b00010) begin n_bad++; $display("FAIL stall_release got stall=%b ready=%b want 0/0010", pipe_stall, req_ready); end
    exp_q.push_back(ent_t'{16'h0021, 4'd2});
    tick();
    pipe_out_valid = 1'b0; req_valid = '0;
    e = exp_q.pop_front();
    n_cmp++; if ({pipe_valid, pipe_address, pipe_id} !== {1'b1, e.addr, e.id}) begin n_bad++; $display("FAIL stall_next got %b/%h/%h want 1/%h/%h", pipe_valid, pipe_address, pipe_id, e.addr, e.id); end
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL stall_swap got %0d want 1", inflight); end
    pipe_out_valid = 1'b1;
    tick();
    pipe_out_valid = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 16'h0040 + 16'(k), IW'(k));
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    n_cmp++; if (inflight !== 4'd3) begin n_bad++; $display("FAIL drain_fill got %0d want 3", inflight); end
    drain_req = 1'b1; pipe_out_valid = 1'b1;
    tick();
    req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({req_ready, drain_done} !== 5'b00000) begin n_bad++; $display("FAIL drain_busy c=%0d got ready=%b done=%b want 0000/0", c, req_ready, drain_done); end
      tick();
    end
    pipe_out_valid = 1'b0;
    #1;
    n_cmp++; if ({inflight, drain_done} !== 5'b00001) begin n_bad++; $display("FAIL drain_pulse got inflight=%0d done=%b want 0/1", inflight, drain_done); end
    tick();
    n_cmp++; if ({req_ready, drain_done} !== 5'b00000) begin n_bad++; $display("FAIL drain_once got ready=%b done=%b want 0000/0", req_ready, drain_done); end
    drain_req = 1'b0;
    tick();
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL drain_resume got %b want 1000", req_ready); end
    exp_q.push_back(ent_t'{16'h0043, 4'd3});
    tick();
    req_valid = '0;
    e = exp_q.pop_front();
    n_cmp++; if ({pipe_valid, pipe_address, pipe_id} !== {1'b1, e.addr, e.id}) begin n_bad++; $display("FAIL drain_issue got %b/%h/%h want 1/%h/%h", pipe_valid, pipe_address, pipe_id, e.addr, e.id); end
    pipe_out_valid = 1'b1;
    tick();
    pipe_out_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    set_req(2, 16'h0030, 4'd6);
    set_req(0, 16'h0031, 4'd7);
    req_valid = 4'b0100;
    exp_q.push_back(ent_t'{16'h0030, 4'd6});
    tick();
    e = exp_q.pop_front();
    req_valid = 4'b0001; flush_req = 1'b1; flush_req_id = 4'd5; pipe_out_valid = 1'b1; down_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_wait_ready c=%0d got %b want 0000", c, req_ready); end
      tick();
      n_cmp++; if ({pipe_flush, flush_ack, pipe_valid, pipe_address} !== {3'b001, e.addr}) begin n_bad++; $display("FAIL flush_wait c=%0d got flush=%b ack=%b valid=%b addr=%h want 0/0/1/%h", c, pipe_flush, flush_ack, pipe_valid, pipe_address, e.addr); end
    end
    down_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_priority got %b want 0000", req_ready); end
    tick();
    n_cmp++; if ({pipe_flush, flush_ack, pipe_valid, pipe_flush_id} !== {3'b110, 4'd5}) begin n_bad++; $display("FAIL flush_inject got flush=%b ack=%b valid=%b id=%0d want 1/1/0/5", pipe_flush, flush_ack, pipe_valid, pipe_flush_id); end
    n_cmp++; if ({req_ready, inflight} !== 8'h00) begin n_bad++; $display("FAIL flush_noissue got ready=%b inflight=%0d want 0000/0", req_ready, inflight); end
    flush_req = 1'b0; pipe_out_valid = 1'b0;
    tick();
    n_cmp++; if ({pipe_flush, flush_ack} !== 2'b00) begin n_bad++; $display("FAIL flush_once got flush=%b ack=%b want 0/0", pipe_flush, flush_ack); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL flush_resume got %b want 0001", req_ready); end
    exp_q.push_back(ent_t'{16'h0031, 4'd7});
    tick();
    req_valid = '0;
    e = exp_q.pop_front();
    n_cmp++; if ({pipe_valid, pipe_address, pipe_id, pipe_flush_id} !== {1'b1, e.addr, e.id, 4'd5}) begin n_bad++; $display("FAIL flush_after got %b/%h/%h/%h want 1/%h/%h/5", pipe_valid, pipe_address, pipe_id, pipe_flush_id, e.addr, e.id); end
    pipe_out_valid = 1'b1;
    tick();
    pipe_out_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_req(0, 16'h0050, 4'd9);
    req_valid = 4'b0001;
    repeat (3) tick();
    n_cmp++; if (inflight !== 4'(MAXI - 1)) begin n_bad++; $display("FAIL b2b_fill got %0d want %0d", inflight, MAXI - 1); end
    pipe_out_valid = 1'b1; down_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_ready got %b want 0001", req_ready); end
    tick();
    n_cmp++; if ({pipe_valid, inflight} !== {1'b1, 4'(MAXI - 1)}) begin n_bad++; $display("FAIL b2b_same got valid=%b inflight=%0d want 1/%0d", pipe_valid, inflight, MAXI - 1); end
    pipe_out_valid = 1'b0; req_valid = '1;
    tick();
    n_cmp++; if ({inflight, pipe_flush_id} !== {4'(MAXI), 4'd5}) begin n_bad++; $display("FAIL b2b_full got inflight=%0d fid=%0d want %0d/5", inflight, pipe_flush_id, MAXI); end
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = '0;
    n_cmp++; if ({pipe_valid, pipe_flush, flush_ack, drain_done} !== 4'b0000) begin n_bad++; $display("FAIL midreset_flags got %b want 0000", {pipe_valid, pipe_flush, flush_ack, drain_done}); end
    n_cmp++; if ({pipe_address, pipe_id, pipe_flush_id, inflight} !== '0) begin n_bad++; $display("FAIL midreset_regs got %h/%h/%h/%0d want 0/0/0/0", pipe_address, pipe_id, pipe_flush_id, inflight); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drain();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
